// File: rtl/axi_master_burst_engine.sv
// Turns a command + beat-stream interface into single-ID AXI4 INCR bursts,
// one transaction at a time, with a one-cycle completion pulse.
module axi_master_burst_engine #(
   parameter int C_AXI_ADDR_WIDTH = 12,
   parameter int C_AXI_DATA_WIDTH = 128,
   parameter int STRB_WIDTH       = C_AXI_DATA_WIDTH / 8,
   parameter int ID_WIDTH         = 1,
   parameter int AXI_ID           = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]                  cmd_len,
   input  logic [C_AXI_DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_WIDTH-1:0]       wr_strb,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   output logic [C_AXI_DATA_WIDTH-1:0] rd_data,
   output logic                        rd_last,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic                        done_valid,
   output logic [1:0]                  done_resp,
   output logic                        done_err,
   output logic                        busy,
   output logic [ID_WIDTH-1:0]         m_axi_awid,
   output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,
   output logic                        m_axi_awlock,
   output logic [3:0]                  m_axi_awcache,
   output logic [2:0]                  m_axi_awprot,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0]       m_axi_wstrb,
   output logic                        m_axi_wlast,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   input  logic [ID_WIDTH-1:0]         m_axi_bid,
   input  logic [1:0]                  m_axi_bresp,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   output logic [ID_WIDTH-1:0]         m_axi_arid,
   output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   output logic                        m_axi_arlock,
   output logic [3:0]                  m_axi_arcache,
   output logic [2:0]                  m_axi_arprot,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   input  logic [ID_WIDTH-1:0]         m_axi_rid,
   input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rlast,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready
);

   localparam logic [ID_WIDTH-1:0] ID_C = ID_WIDTH'(AXI_ID);
   localparam logic [2:0]          SIZE = 3'($clog2(STRB_WIDTH));

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

   state_t                        state;
   logic [C_AXI_ADDR_WIDTH-1:0]   burst_addr;
   logic [7:0]                    burst_len;
   logic [7:0]                    beat_cnt;
   logic [1:0]                    resp_acc;
   logic [1:0]                    rresp_max;
   logic                          w_hs;
   logic                          r_hs;
   logic                          r_end;
   logic                          cnt_zero;

   // done_valid also marks the closing cycle of B/R: the channel is gated
   // off so nothing more is accepted before returning to IDLE.
   assign cnt_zero  = (beat_cnt == 8'd0);
   assign w_hs      = (state == S_W) && wr_valid && m_axi_wready;
   assign r_hs      = (state == S_R) && !done_valid && m_axi_rvalid && rd_ready;
   assign r_end     = r_hs && (m_axi_rlast || cnt_zero);
   assign rresp_max = (m_axi_rresp > resp_acc) ? m_axi_rresp : resp_acc;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   assign m_axi_wvalid = (state == S_W) && wr_valid;
   assign wr_ready     = (state == S_W) && m_axi_wready;
   assign m_axi_wdata  = wr_data;
   assign m_axi_wstrb  = wr_strb;
   assign m_axi_wlast  = (state == S_W) && cnt_zero;
   assign m_axi_bready = (state == S_B) && !done_valid;

   assign rd_valid     = (state == S_R) && !done_valid && m_axi_rvalid;
   assign m_axi_rready = (state == S_R) && !done_valid && rd_ready;
   assign rd_data      = m_axi_rdata;
   assign rd_last      = m_axi_rlast;

   assign m_axi_awid    = ID_C;
   assign m_axi_awaddr  = burst_addr;
   assign m_axi_awlen   = burst_len;
   assign m_axi_awsize  = SIZE;
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arid    = ID_C;
   assign m_axi_araddr  = burst_addr;
   assign m_axi_arlen   = burst_len;
   assign m_axi_arsize  = SIZE;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         burst_addr    <= '0;
         burst_len     <= '0;
         beat_cnt      <= '0;
         resp_acc      <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_arvalid <= 1'b0;
         done_valid    <= 1'b0;
         done_resp     <= 2'b00;
         done_err      <= 1'b0;
      end else begin
         done_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  burst_addr <= cmd_addr;
                  burst_len  <= cmd_len;
                  beat_cnt   <= cmd_len;
                  resp_acc   <= 2'b00;
                  done_err   <= 1'b0;
                  if (cmd_write) begin
                     m_axi_awvalid <= 1'b1;
                     state         <= S_AW;
                  end else begin
                     m_axi_arvalid <= 1'b1;
                     state         <= S_AR;
                  end
               end
            end
            S_AW: begin
               if (m_axi_awready) begin
                  m_axi_awvalid <= 1'b0;
                  state         <= S_W;
               end
            end
            S_W: begin
               if (w_hs) begin
                  if (cnt_zero) state <= S_B;
                  else          beat_cnt <= beat_cnt - 8'd1;
               end
            end
            S_B: begin
               if (done_valid) begin
                  state <= S_IDLE;
               end else if (m_axi_bvalid) begin
                  done_valid <= 1'b1;
                  done_resp  <= m_axi_bresp;
                  done_err   <= (m_axi_bid != ID_C);
               end
            end
            S_AR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  state         <= S_R;
               end
            end
            S_R: begin
               if (done_valid) begin
                  state <= S_IDLE;
               end else if (r_hs) begin
                  resp_acc <= rresp_max;
                  // Hold at zero on the final beat so len=255 never wraps.
                  if (!cnt_zero) beat_cnt <= beat_cnt - 8'd1;
                  done_err <= done_err || (m_axi_rid != ID_C) ||
                              (r_end && (m_axi_rlast != cnt_zero));
                  if (r_end) begin
                     done_valid <= 1'b1;
                     done_resp  <= rresp_max;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_master_burst_engine.sv
// Randomized bench: the bench plays AXI slave and stream source/sink, and
// predicts beats, responses and error flags from the burst rules.
module tb_axi_master_burst_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid, cmd_ready, cmd_write;
   logic [11:0]  cmd_addr;
   logic [7:0]   cmd_len;
   logic [127:0] wr_data;
   logic [15:0]  wr_strb;
   logic         wr_valid, wr_ready;
   logic [127:0] rd_data;
   logic         rd_last, rd_valid, rd_ready;
   logic         done_valid, done_err, busy;
   logic [1:0]   done_resp;
   logic [0:0]   m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
   logic [11:0]  m_axi_awaddr, m_axi_araddr;
   logic [7:0]   m_axi_awlen, m_axi_arlen;
   logic [2:0]   m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
   logic [1:0]   m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic         m_axi_awlock, m_axi_arlock;
   logic [3:0]   m_axi_awcache, m_axi_arcache;
   logic         m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
   logic [127:0] m_axi_wdata, m_axi_rdata;
   logic [15:0]  m_axi_wstrb;
   logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic         m_axi_bvalid, m_axi_bready;
   logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   axi_master_burst_engine dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err), .busy(busy),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   task automatic idle_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = '0; m_axi_bresp = '0;
      m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0;
      m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
   endtask

   // One write burst; fast = slave always ready, gaps = source stalls every other cycle.
   task automatic do_write(input logic [11:0] addr, input logic [7:0] len, input bit fast,
                           input bit gaps, input logic [1:0] bresp, input logic bid);
      logic [127:0] wd[$];
      logic [15:0]  ws[$];
      int n = int'(len) + 1;
      int wi = 0, aw_cnt = 0, cyc = 0;
      bit bsent = 0, seen = 0;
      for (int i = 0; i < n; i++) begin
         wd.push_back(fast ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom});
         ws.push_back(fast ? 16'hFFFF : 16'($urandom));
      end
      @(negedge clk);
      cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len;
      #1;
      n_chk++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 0;
      while (!seen && cyc < 3000) begin
         m_axi_awready = fast ? 1'b1 : 1'($urandom_range(0, 1));
         m_axi_wready  = fast ? 1'b1 : 1'($urandom_range(0, 1));
         wr_valid      = (wi < n) && (!gaps || (cyc % 2 == 0));
         if (wi < n) begin wr_data = wd[wi]; wr_strb = ws[wi]; end
         m_axi_bvalid  = (wi == n) && !bsent && (fast || 1'($urandom_range(0, 1)));
         m_axi_bresp   = bresp;
         m_axi_bid     = bid;
         #1;
         if (m_axi_wvalid && aw_cnt == 0) begin
            n_chk++; n_fail++; $display("FAIL w_before_aw: wvalid=1 before AW accepted");
         end
         if (m_axi_awvalid && m_axi_awready) begin
            aw_cnt++;
            n_chk++;
            if ({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache,
                 m_axi_awid, m_axi_awlock, m_axi_awprot} !==
                {addr, len, 3'd4, 2'b01, 4'b0011, 1'b0, 1'b0, 3'b000}) begin
               n_fail++;
               $display("FAIL aw_fields: addr %h len %h size %h burst %b want %h %h 4 01",
                        m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, addr, len);
            end
         end
         if (m_axi_wvalid) begin
            n_chk++;
            if (wr_ready !== m_axi_wready) begin
               n_fail++; $display("FAIL wr_ready_mirror: got %b want %b", wr_ready, m_axi_wready);
            end
            if (m_axi_wready) begin
               n_chk++;
               if ({m_axi_wdata, m_axi_wstrb, m_axi_wlast} !== {wd[wi], ws[wi], (wi == n - 1)}) begin
                  n_fail++;
                  $display("FAIL w_beat%0d: data %h strb %h last %b want %h %h %b", wi,
                           m_axi_wdata, m_axi_wstrb, m_axi_wlast, wd[wi], ws[wi], (wi == n - 1));
               end
               wi++;
            end
         end
         if (m_axi_bvalid && m_axi_bready) bsent = 1;
         if (done_valid) begin
            seen = 1;
            n_chk++;
            if ({done_resp, done_err, bsent, cmd_ready} !== {bresp, (bid != 1'b0), 1'b1, 1'b0}) begin
               n_fail++;
               $display("FAIL wr_done: resp %b err %b bsent %b cmd_ready %b want %b %b 1 0",
                        done_resp, done_err, bsent, cmd_ready, bresp, (bid != 1'b0));
            end
         end
         @(negedge clk);
         cyc++;
      end
      wr_valid = 0; m_axi_bvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
      #1;
      n_chk++;
      if (!seen || aw_cnt != 1 || wi != n || cmd_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_end: done %0d aw %0d beats %0d ready %b busy %b want 1 1 %0d 1 0",
                  seen, aw_cnt, wi, cmd_ready, busy, n);
      end
   endtask

   // One read burst. rmode: 0 random rd_ready, 1 toggling, 2 always ready.
   // Slave asserts rlast on beat last_at; resp of beat j = resp_pat[2*(j%4)+:2].
   task automatic do_read(input logic [11:0] addr, input logic [7:0] len, input int rmode,
                          input int last_at, input logic rid, input logic [7:0] resp_pat);
      logic [127:0] rq[$];
      int n_exp, j = 0, ar_cnt = 0, cyc = 0;
      bit seen = 0, exp_err;
      logic [1:0] exp_resp = 2'b00, r;
      n_exp   = ((last_at < int'(len)) ? last_at : int'(len)) + 1;
      exp_err = (last_at != int'(len)) || (rid != 1'b0);
      for (int i = 0; i <= last_at; i++) rq.push_back({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < n_exp; i++) begin
         r = resp_pat[2*(i%4) +: 2];
         if (r > exp_resp) exp_resp = r;
      end
      @(negedge clk);
      cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = len;
      @(negedge clk);
      cmd_valid = 0;
      while (!seen && cyc < 3000) begin
         m_axi_arready = (rmode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         rd_ready      = (rmode == 2) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         m_axi_rvalid  = (ar_cnt > 0) && (j <= last_at) && ((rmode == 2) || 1'($urandom_range(0, 1)));
         if (j <= last_at) m_axi_rdata = rq[j];
         m_axi_rresp   = resp_pat[2*(j%4) +: 2];
         m_axi_rlast   = (j == last_at);
         m_axi_rid     = rid;
         #1;
         if (m_axi_arvalid && m_axi_arready) begin
            ar_cnt++;
            n_chk++;
            if ({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid} !==
                {addr, len, 3'd4, 2'b01, 4'b0011, 1'b0}) begin
               n_fail++;
               $display("FAIL ar_fields: addr %h len %h size %h burst %b want %h %h 4 01",
                        m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, addr, len);
            end
         end
         if (rd_valid) begin
            n_chk++;
            if (m_axi_rready !== rd_ready) begin
               n_fail++; $display("FAIL rready_mirror: got %b want %b", m_axi_rready, rd_ready);
            end
            if (rd_ready) begin
               n_chk++;
               if (j >= n_exp || {rd_data, rd_last} !== {rq[j], (j == last_at)}) begin
                  n_fail++;
                  $display("FAIL rd_beat%0d: data %h last %b (beats expected %0d)", j, rd_data, rd_last, n_exp);
               end
               j++;
            end
         end
         if (done_valid) begin
            seen = 1;
            n_chk++;
            if ({done_resp, done_err, cmd_ready} !== {exp_resp, exp_err, 1'b0} || j != n_exp) begin
               n_fail++;
               $display("FAIL rd_done: resp %b err %b beats %0d want %b %b %0d",
                        done_resp, done_err, j, exp_resp, exp_err, n_exp);
            end
         end
         @(negedge clk);
         cyc++;
      end
      m_axi_rvalid = 0; m_axi_rlast = 0; rd_ready = 0; m_axi_arready = 0;
      #1;
      n_chk++;
      if (!seen || ar_cnt != 1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_end: done %0d ar %0d ready %b busy %b want 1 1 1 0", seen, ar_cnt, cmd_ready, busy);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rd_valid,
           done_valid, done_err, busy, done_resp, cmd_ready} !== 12'b0000_0000_0001) begin
         n_fail++;
         $display("FAIL reset_state: aw %b w %b b %b ar %b r %b rd %b dv %b de %b busy %b resp %b rdy %b",
                  m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rd_valid,
                  done_valid, done_err, busy, done_resp, cmd_ready);
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_single_write();
      do_write(12'h040, 8'd0, 1, 0, 2'b00, 1'b0);
   endtask

   task automatic test_read_toggle();
      do_read(12'h100, 8'd3, 1, 3, 1'b0, 8'h00);
   endtask

   task automatic test_write_gaps();
      do_write(12'h200, 8'd7, 0, 1, 2'b00, 1'b0);
   endtask

   task automatic test_resp();
      do_write(12'h300, 8'd2, 0, 0, 2'b10, 1'b0);
      do_read(12'h310, 8'd2, 0, 2, 1'b0, 8'b00_00_11_00);
      do_write(12'h320, 8'd1, 0, 0, 2'b00, 1'b1);
      do_read(12'h330, 8'd1, 2, 1, 1'b1, 8'h00);
   endtask

   task automatic test_early_last();
      do_read(12'h400, 8'd3, 0, 1, 1'b0, 8'h00);
      do_read(12'h410, 8'd1, 2, 3, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid_burst();
      int wi = 0, cyc = 0;
      @(negedge clk);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h500; cmd_len = 8'd7;
      @(negedge clk);
      cmd_valid = 0; m_axi_awready = 1; m_axi_wready = 1; wr_valid = 1; wr_data = '1; wr_strb = '1;
      while (wi < 2 && cyc < 50) begin
         #1;
         if (m_axi_wvalid && m_axi_wready) wi++;
         @(negedge clk);
         cyc++;
      end
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      n_chk++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rd_valid,
           done_valid, busy, cmd_ready} !== 9'b0000_0000_1 || wi != 2) begin
         n_fail++;
         $display("FAIL rst_mid_burst: aw %b w %b dv %b busy %b rdy %b beats %0d want 0 0 0 0 1 2",
                  m_axi_awvalid, m_axi_wvalid, done_valid, busy, cmd_ready, wi);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         n_chk++;
         if (done_valid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_done: done_valid %b wvalid %b want 0 0", done_valid, m_axi_wvalid);
         end
      end
      idle_inputs();
      do_write(12'h510, 8'd3, 0, 0, 2'b01, 1'b0);
   endtask

   task automatic test_len255();
      do_read(12'h000, 8'd255, 2, 255, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [11:0] a;
      logic [7:0]  l;
      for (int k = 0; k < 10; k++) begin
         a = 12'($urandom) & 12'hFF0;
         l = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) do_write(a, l, 0, 0, 2'($urandom), 1'b0);
         else                           do_read(a, l, 0, int'(l), 1'b0, 8'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_toggle();
      test_write_gaps();
      test_resp();
      test_early_last();
      test_reset_mid_burst();
      test_len255();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_master_burst_engine.md
Name: axi_master_burst_engine

Overview:
- AXI4 initiator that converts a simple command/stream interface into single-ID INCR bursts on an AXI4 master port.
- Used to drive AXI4 slave memories (e.g. the fake AXI4 RAM in the verification environment) from testbench or DMA-style logic.
- One transaction in flight at a time; no reordering.

Parameters:
- C_AXI_ADDR_WIDTH, 12, AXI address width in bits.
- C_AXI_DATA_WIDTH, 128, AXI data width in bits; power of two, >= 8.
- STRB_WIDTH, C_AXI_DATA_WIDTH/8, write strobe width.
- ID_WIDTH, 1, AXI ID width.
- AXI_ID, 0, constant value driven on awid/arid.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid/cmd_ready  in/out  1/1  command handshake; cmd_ready = (state==IDLE)
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  C_AXI_ADDR_WIDTH  byte start address; low log2(STRB_WIDTH) bits must be 0
cmd_len  in  8  beats minus one (AXI awlen/arlen encoding)
wr_data/wr_strb  in  C_AXI_DATA_WIDTH/STRB_WIDTH  write beat payload
wr_valid/wr_ready  in/out  1/1  write beat handshake
rd_data  out  C_AXI_DATA_WIDTH  read beat payload
rd_last  out  1  final beat of read burst
rd_valid/rd_ready  out/in  1/1  read beat handshake
done_valid  out  1  one-cycle pulse at transaction completion
done_resp  out  2  worst response seen (max of bresp, or of all rresp)
done_err  out  1  beat-count/last mismatch detected
busy  out  1  state != IDLE
m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  ID_WIDTH/ADDR/8/3/2/1/4/3/1  AW channel
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  DATA/STRB/1/1  W channel; m_axi_wready  in  1
m_axi_bid/bresp/bvalid  in  ID_WIDTH/2/1  B channel; m_axi_bready  out  1
m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  as AW  AR channel
m_axi_arready  in  1
m_axi_rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA/2/1/1  R channel; m_axi_rready  out  1

Behaviour:
- Reset: state IDLE; awvalid, wvalid, bready, arvalid, rready, rd_valid, done_valid, done_err, busy = 0; done_resp = 2'b00; beat counter = 0. Reset mid-burst abandons the transaction; no completion pulse.
- Constants: awsize = arsize = log2(STRB_WIDTH); awburst = arburst = 2'b01 (INCR); lock = 0; cache = 4'b0011; prot = 3'b000; awid = arid = AXI_ID.
- States: IDLE, AW, W, B, AR, R.
- IDLE: on cmd_valid && cmd_ready, register addr and len; load beat counter = cmd_len; clear resp accumulator and err. Go to AW if cmd_write, else AR.
- AW / AR: awvalid/arvalid registered high from the cycle after acceptance; addr and len held stable until ready. On awready go to W; on arready go to R.
- W, combinational pass-through:
  - wvalid = wr_valid; wr_ready = m_axi_wready; wdata/wstrb = wr_data/wr_strb.
  - wlast = (counter == 0).
  - Each accepted beat decrements counter; beat with counter==0 moves to B.
  - wvalid is never asserted before AW is accepted.
- B: bready = 1. On bvalid, done_resp = bresp and done_err = (bid != AXI_ID); pulse done_valid for 1 cycle; return to IDLE. cmd_ready rises in the cycle after the pulse.
- R, combinational pass-through:
  - rd_valid = rvalid; rready = rd_ready; rd_data = rdata; rd_last = rlast.
  - Accepted beats decrement the counter; resp accumulator = max(accumulator, rresp).
  - done_err set if rlast arrives with counter != 0, or counter == 0 without rlast, or rid != AXI_ID.
  - Transaction ends on the accepted beat with rlast or counter == 0, whichever comes first; then done_valid pulses and state returns to IDLE.
- Counter is 8 bits; len = 255 yields exactly 256 beats; no wrap before the final beat.
- Address never crosses a 4 KB boundary check: caller responsibility; not enforced.
- Back-pressure: stall on any ready/valid low indefinitely, with no loss or duplication of beats.

Test Plan:
- Write addr 0x040, len 0, data 0xA5.., strb all-ones, slave ready -> one AW (awlen=0, awsize=4), one W with wlast=1, done_valid pulse with done_resp=00, done_err=0.
- Read addr 0x100, len 3, rd_ready toggling 1/0 each cycle -> four rd beats in order, rd_last on the 4th only, rready mirrors rd_ready, done_resp=00.
- Write len 7 with wr_valid gaps every other cycle -> 8 W beats, wlast only on the 8th, no AW reissue.
- Slave returns bresp=2'b10 -> done_resp=10; a read with rresp 00,11,00 -> done_resp=11.
- Slave asserts rlast on beat 2 of len 3 -> done_err=1, transaction ends, busy drops.
- Assert rst during W beat 3 of len 7 -> next cycle all valids 0, state IDLE, cmd_ready=1, no done_valid.
- Len 255 read -> exactly 256 beats accepted, rd_last on beat 256, counter ends at 0.
